// File: rtl/half_adder.sv
// Bit-parallel half adder with a registered, valid-qualified result copy and a saturating carry-event counter.
// Latency: S/C are combinational (0 cycles); S_q/C_q/out_valid/carry_cnt update 1 cycle after acceptance.
// Backpressure: none; each accepted input yields exactly one single-cycle result.
module half_adder #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] C,
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic [WIDTH-1:0] S_q,
    output logic [WIDTH-1:0] C_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] carry_cnt
);

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] c;
    } ha_res_t;

    ha_res_t res;

    // Pure function of A/B so a bare four-port instance works with clk/rst/in_valid floating.
    always_comb begin
        res.s = A ^ B;
        res.c = A & B;
    end

    assign S = res.s;
    assign C = res.c;

    always_ff @(posedge clk) begin
        if (rst) begin
            S_q       <= '0;
            C_q       <= '0;
            out_valid <= 1'b0;
            carry_cnt <= '0;
        end else if (in_valid) begin
            S_q       <= res.s;
            C_q       <= res.c;
            out_valid <= 1'b1;
            if ((|res.c) && (carry_cnt != {CNT_W{1'b1}})) begin
                carry_cnt <= carry_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_half_adder.sv
// Bench for half_adder: an 8-lane instance with a 2-bit counter and a 1-lane instance with the default counter,
// both driven from the same stimulus and checked against a queue-based scoreboard plus per-scenario checks.
module tb_half_adder;

    logic        clk    = 1'b0;
    logic        clk_en = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  a8, b8;

    logic [7:0]  s8, c8, sq8, cq8;
    logic        ov8;
    logic [1:0]  cnt8;

    logic        s1, c1, sq1, cq1, ov1;
    logic [15:0] cnt1;

    int checks = 0;
    int errors = 0;

    half_adder #(.WIDTH(8), .CNT_W(2)) u_w8 (
        .A(a8), .B(b8), .S(s8), .C(c8),
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .S_q(sq8), .C_q(cq8), .out_valid(ov8), .carry_cnt(cnt8)
    );

    half_adder #(.WIDTH(1), .CNT_W(16)) u_w1 (
        .A(a8[0:0]), .B(b8[0:0]), .S(s1), .C(c1),
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .S_q(sq1), .C_q(cq1), .out_valid(ov1), .carry_cnt(cnt1)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    typedef struct packed {
        logic [7:0] s;
        logic [7:0] c;
    } res8_t;

    res8_t       q8[$];
    logic [1:0]  q1[$];

    // Architectural model of the registered state, advanced when stimulus is driven.
    logic [7:0]  m_sq8 = '0, m_cq8 = '0;
    logic [1:0]  m_cnt8 = '0;
    logic        m_sq1 = 1'b0, m_cq1 = 1'b0;
    logic [15:0] m_cnt1 = '0;

    task automatic drive(input logic r, input logic v, input logic [7:0] a, input logic [7:0] b);
        rst      = r;
        in_valid = v;
        a8       = a;
        b8       = b;
        if (r) begin
            m_sq8 = '0; m_cq8 = '0; m_cnt8 = '0;
            m_sq1 = 1'b0; m_cq1 = 1'b0; m_cnt1 = '0;
        end else if (v) begin
            q8.push_back({a ^ b, a & b});
            q1.push_back({a[0] ^ b[0], a[0] & b[0]});
            m_sq8 = a ^ b;
            m_cq8 = a & b;
            if ((|(a & b)) && m_cnt8 != 2'd3) m_cnt8 = m_cnt8 + 2'd1;
            m_sq1 = a[0] ^ b[0];
            m_cq1 = a[0] & b[0];
            if ((a[0] & b[0]) && m_cnt1 != 16'hFFFF) m_cnt1 = m_cnt1 + 16'd1;
        end
    endtask

    // Scoreboard: every accepted input must surface on the very next edge, nothing else may.
    always @(posedge clk) begin
        res8_t      e8;
        logic [1:0] e1;
        #1;
        checks++;
        if (q8.size() > 0) begin
            e8 = q8.pop_front();
            if (ov8 !== 1'b1 || sq8 !== e8.s || cq8 !== e8.c) begin
                errors++;
                $display("FAIL sb_w8_result: got ov=%b S_q=%h C_q=%h, want ov=1 S_q=%h C_q=%h", ov8, sq8, cq8, e8.s, e8.c);
            end
        end else if (ov8 !== 1'b0) begin
            errors++;
            $display("FAIL sb_w8_spurious_valid: got ov=%b, want 0", ov8);
        end
        checks++;
        if (sq8 !== m_sq8 || cq8 !== m_cq8 || cnt8 !== m_cnt8) begin
            errors++;
            $display("FAIL sb_w8_state: got S_q=%h C_q=%h cnt=%0d, want S_q=%h C_q=%h cnt=%0d", sq8, cq8, cnt8, m_sq8, m_cq8, m_cnt8);
        end
        checks++;
        if (q1.size() > 0) begin
            e1 = q1.pop_front();
            if (ov1 !== 1'b1 || sq1 !== e1[1] || cq1 !== e1[0]) begin
                errors++;
                $display("FAIL sb_w1_result: got ov=%b S_q=%b C_q=%b, want ov=1 S_q=%b C_q=%b", ov1, sq1, cq1, e1[1], e1[0]);
            end
        end else if (ov1 !== 1'b0) begin
            errors++;
            $display("FAIL sb_w1_spurious_valid: got ov=%b, want 0", ov1);
        end
        checks++;
        if (sq1 !== m_sq1 || cq1 !== m_cq1 || cnt1 !== m_cnt1) begin
            errors++;
            $display("FAIL sb_w1_state: got S_q=%b C_q=%b cnt=%0d, want S_q=%b C_q=%b cnt=%0d", sq1, cq1, cnt1, m_sq1, m_cq1, m_cnt1);
        end
    end

    task automatic test_comb();
        logic [1:0] tbl [4];
        logic [1:0] ab;
        logic [1:0] want;
        tbl = '{2'b00, 2'b10, 2'b10, 2'b01};
        rst      = 1'bx;
        in_valid = 1'bx;
        for (int i = 0; i < 4; i++) begin
            ab = i[1:0];
            a8 = {7'd0, ab[1]};
            b8 = {7'd0, ab[0]};
            #1;
            want = tbl[i];
            checks++;
            if ({s1, c1} !== want) begin
                errors++;
                $display("FAIL comb_w1_ab%b: got SC=%b%b, want %b", ab, s1, c1, want);
            end
        end
        a8 = 8'hF0; b8 = 8'h3C;
        #1;
        checks++;
        if (s8 !== 8'hCC || c8 !== 8'h30) begin
            errors++;
            $display("FAIL comb_w8: got S=%h C=%h, want S=cc C=30", s8, c8);
        end
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 8'h00, 8'h00);
        clk_en = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (ov8 !== 1'b0 || sq8 !== 8'h00 || cq8 !== 8'h00 || cnt8 !== 2'd0 || ov1 !== 1'b0 || cnt1 !== 16'd0) begin
            errors++;
            $display("FAIL reset_values: got ov8=%b S_q8=%h C_q8=%h cnt8=%0d ov1=%b cnt1=%0d, want all zero", ov8, sq8, cq8, cnt8, ov1, cnt1);
        end
        drive(1'b1, 1'b1, 8'hF0, 8'h3C);
        #1;
        checks++;
        if (s8 !== 8'hCC || c8 !== 8'h30) begin
            errors++;
            $display("FAIL comb_during_reset: got S=%h C=%h, want S=cc C=30", s8, c8);
        end
        @(posedge clk);
        #2;
        checks++;
        if (ov8 !== 1'b0 || cnt8 !== 2'd0 || ov1 !== 1'b0 || cnt1 !== 16'd0) begin
            errors++;
            $display("FAIL reset_beats_valid: got ov8=%b cnt8=%0d ov1=%b cnt1=%0d, want 0 0 0 0", ov8, cnt8, ov1, cnt1);
        end
    endtask

    task automatic test_registered();
        drive(1'b0, 1'b1, 8'h01, 8'h01);
        @(posedge clk);
        #2;
        checks++;
        if (sq1 !== 1'b0 || cq1 !== 1'b1 || ov1 !== 1'b1 || cnt1 !== 16'd1) begin
            errors++;
            $display("FAIL registered_first: got S_q=%b C_q=%b ov=%b cnt=%0d, want 0 1 1 1", sq1, cq1, ov1, cnt1);
        end
        drive(1'b0, 1'b0, 8'h02, 8'h00);
        @(posedge clk);
        #2;
        checks++;
        if (ov1 !== 1'b0 || sq1 !== 1'b0 || cq1 !== 1'b1 || cnt1 !== 16'd1) begin
            errors++;
            $display("FAIL registered_hold: got S_q=%b C_q=%b ov=%b cnt=%0d, want 0 1 0 1", sq1, cq1, ov1, cnt1);
        end
    endtask

    task automatic test_multilane();
        drive(1'b0, 1'b1, 8'hF0, 8'h3C);
        #1;
        checks++;
        if (s8 !== 8'hCC || c8 !== 8'h30) begin
            errors++;
            $display("FAIL multilane_comb: got S=%h C=%h, want cc 30", s8, c8);
        end
        @(posedge clk);
        #2;
        checks++;
        if (sq8 !== 8'hCC || cq8 !== 8'h30 || ov8 !== 1'b1) begin
            errors++;
            $display("FAIL multilane_reg: got S_q=%h C_q=%h ov=%b, want cc 30 1", sq8, cq8, ov8);
        end
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        @(posedge clk);
        #2;
    endtask

    task automatic test_saturation();
        logic [1:0] want;
        drive(1'b1, 1'b0, 8'h00, 8'h00);
        @(posedge clk);
        #2;
        for (int k = 0; k < 5; k++) begin
            want = (k + 1 > 3) ? 2'd3 : 2'(k + 1);
            drive(1'b0, 1'b1, 8'hFF, 8'h0F);
            @(posedge clk);
            #2;
            checks++;
            if (cnt8 !== want) begin
                errors++;
                $display("FAIL sat_carry_%0d: got cnt=%0d, want %0d", k, cnt8, want);
            end
            drive(1'b0, 1'b1, 8'hF0, 8'h0F);
            @(posedge clk);
            #2;
            checks++;
            if (cnt8 !== want || ov8 !== 1'b1) begin
                errors++;
                $display("FAIL sat_nocarry_%0d: got cnt=%0d ov=%b, want %0d 1", k, cnt8, ov8, want);
            end
        end
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        @(posedge clk);
        #2;
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 40; k++) begin
            drive(1'b0, ($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom));
            @(posedge clk);
            #2;
        end
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset_mid();
        repeat (3) begin
            drive(1'b0, 1'b1, 8'hFF, 8'hFF);
            @(posedge clk);
            #2;
        end
        drive(1'b1, 1'b1, 8'hFF, 8'hFF);
        @(posedge clk);
        #2;
        checks++;
        if (ov8 !== 1'b0 || cnt8 !== 2'd0 || ov1 !== 1'b0 || cnt1 !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid: got ov8=%b cnt8=%0d ov1=%b cnt1=%0d, want 0 0 0 0", ov8, cnt8, ov1, cnt1);
        end
        drive(1'b0, 1'b1, 8'h01, 8'h01);
        @(posedge clk);
        #2;
        checks++;
        if (cnt1 !== 16'd1 || cnt8 !== 2'd1 || ov1 !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_restart: got cnt1=%0d cnt8=%0d ov1=%b, want 1 1 1", cnt1, cnt8, ov1);
        end
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        @(posedge clk);
        #2;
    endtask

    initial begin
        test_comb();
        test_reset();
        test_registered();
        test_multilane();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
